mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the CPU's instruction-fetch port and data-memory port.
- Uses the CPU's READ/WRITE encoding and BUSYWAIT handshake.
- Data accesses have fixed priority, with a starvation guard that protects instruction fetch.
- Each granted request is latched and held stable on the memory side until the memory completes it.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU fetch port, CPU data port and the unified memory port.
// The arbiter uses the slave view; the CPU/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  INSTR_MEM_READ;
    logic [ADDR_WIDTH-1:0] INSTR_MEM_ADDR;
    logic [DATA_WIDTH-1:0] INSTRUCTION;
    logic                  INSTR_MEM_BUSYWAIT;

    logic [3:0]            DATA_MEM_READ;
    logic [2:0]            DATA_MEM_WRITE;
    logic [ADDR_WIDTH-1:0] DATA_MEM_ADDR;
    logic [DATA_WIDTH-1:0] DATA_MEM_WRITE_DATA;
    logic [DATA_WIDTH-1:0] DATA_MEM_READ_DATA;
    logic                  DATA_MEM_BUSYWAIT;

    logic [3:0]            MEM_READ;
    logic [2:0]            MEM_WRITE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_WRITE_DATA;
    logic [DATA_WIDTH-1:0] MEM_READ_DATA;
    logic                  MEM_BUSYWAIT;

    modport slave (
        input  INSTR_MEM_READ, INSTR_MEM_ADDR,
        input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
        input  MEM_READ_DATA, MEM_BUSYWAIT,
        output INSTRUCTION, INSTR_MEM_BUSYWAIT,
        output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA
    );

    modport master (
        output INSTR_MEM_READ, INSTR_MEM_ADDR,
        output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
        output MEM_READ_DATA, MEM_BUSYWAIT,
        input  INSTRUCTION, INSTR_MEM_BUSYWAIT,
        input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic              CLK,
    input logic              RESET,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic [3:0]            mem_read_q, mem_read_d;
    logic [2:0]            mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic i_req, d_req, done_i, done_d, starve_ok;

    assign i_req     = bus.INSTR_MEM_READ;
    assign d_req     = bus.DATA_MEM_READ[3] | bus.DATA_MEM_WRITE[2];
    assign done_i    = (state_q == GNT_I) && !bus.MEM_BUSYWAIT;
    assign done_d    = (state_q == GNT_D) && !bus.MEM_BUSYWAIT;
    assign starve_ok = starve_q < CW'(STARVE_LIMIT);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || starve_ok)) begin
                    state_d     = GNT_D;
                    mem_write_d = bus.DATA_MEM_WRITE;
                    // a simultaneous read is dropped in favour of the store
                    mem_read_d  = bus.DATA_MEM_WRITE[2] ? 4'b0000 : bus.DATA_MEM_READ;
                    mem_addr_d  = bus.DATA_MEM_ADDR;
                    mem_wdata_d = bus.DATA_MEM_WRITE_DATA;
                    // with a fetch pending this branch implies starve_ok, so +1 never overflows
                    starve_d    = i_req ? starve_q + CW'(1) : '0;
                end else if (i_req) begin
                    state_d     = GNT_I;
                    mem_read_d  = 4'b1010;
                    mem_write_d = 3'b000;
                    mem_addr_d  = bus.INSTR_MEM_ADDR;
                    starve_d    = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (!bus.MEM_BUSYWAIT) begin
                    state_d     = IDLE;
                    mem_read_d  = 4'b0000;
                    mem_write_d = 3'b000;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_d = done_i ? bus.MEM_READ_DATA : instr_q;
    assign rdata_d = done_d ? bus.MEM_READ_DATA : rdata_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_read_q  <= '0;
            mem_write_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.MEM_READ           = mem_read_q;
    assign bus.MEM_WRITE          = mem_write_q;
    assign bus.MEM_ADDR           = mem_addr_q;
    assign bus.MEM_WRITE_DATA     = mem_wdata_q;
    assign bus.INSTR_MEM_BUSYWAIT = i_req & ~done_i;
    assign bus.DATA_MEM_BUSYWAIT  = d_req & ~done_d;
    assign bus.INSTRUCTION        = done_i ? bus.MEM_READ_DATA : instr_q;
    assign bus.DATA_MEM_READ_DATA = done_d ? bus.MEM_READ_DATA : rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // memory responder: holds busywait for wait_n cycles of each active request
    int          wait_n    = 0;
    bit          rand_wait = 1'b0;
    bit          rand_data = 1'b0;
    logic [31:0] fix_rdata = 32'h0;
    int          mcnt      = 0;

    initial begin
        bus.MEM_BUSYWAIT  = 1'b0;
        bus.MEM_READ_DATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.MEM_READ[3] | bus.MEM_WRITE[2]) begin
                if (mcnt < wait_n) begin
                    bus.MEM_BUSYWAIT = 1'b1;
                    mcnt++;
                end else begin
                    bus.MEM_BUSYWAIT = 1'b0;
                    mcnt = 0;
                    if (rand_wait) wait_n = $urandom_range(0, 3);
                end
            end else begin
                bus.MEM_BUSYWAIT = 1'b0;
                mcnt = 0;
            end
            bus.MEM_READ_DATA = rand_data ? $urandom : fix_rdata;
        end
    end

    // reference model: owner 0 = nobody, 1 = fetch, 2 = data
    int          m_owner  = 0;
    logic [3:0]  m_rd     = '0;
    logic [2:0]  m_wr     = '0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_ilast  = '0;
    logic [31:0] m_dlast  = '0;
    int          m_starve = 0;
    int          grant_log[$];
    logic        i_r, d_r, m_done;

    always @(negedge CLK) begin
        if (!RESET) begin
            m_owner  = 0;
            m_rd     = '0;
            m_wr     = '0;
            m_addr   = '0;
            m_wdata  = '0;
            m_ilast  = '0;
            m_dlast  = '0;
            m_starve = 0;
        end
        i_r    = bus.INSTR_MEM_READ;
        d_r    = bus.DATA_MEM_READ[3] | bus.DATA_MEM_WRITE[2];
        m_done = (m_owner != 0) && !bus.MEM_BUSYWAIT;

        chk("m_mem_read",  bus.MEM_READ, m_rd);
        chk("m_mem_write", bus.MEM_WRITE, m_wr);
        chk("m_mem_addr",  bus.MEM_ADDR, m_addr);
        chk("m_mem_wdata", bus.MEM_WRITE_DATA, m_wdata);
        chk("m_ibw", bus.INSTR_MEM_BUSYWAIT, i_r && !(m_owner == 1 && m_done));
        chk("m_dbw", bus.DATA_MEM_BUSYWAIT, d_r && !(m_owner == 2 && m_done));
        chk("m_instr", bus.INSTRUCTION, (m_owner == 1 && m_done) ? bus.MEM_READ_DATA : m_ilast);
        chk("m_rdata", bus.DATA_MEM_READ_DATA, (m_owner == 2 && m_done) ? bus.MEM_READ_DATA : m_dlast);

        if (RESET) begin
            if (m_owner != 0) begin
                if (m_done) begin
                    if (m_owner == 1) m_ilast = bus.MEM_READ_DATA;
                    else              m_dlast = bus.MEM_READ_DATA;
                    m_owner = 0;
                    m_rd    = '0;
                    m_wr    = '0;
                end
            end else if (d_r && (!i_r || m_starve < SL)) begin
                m_owner  = 2;
                m_wr     = bus.DATA_MEM_WRITE;
                m_rd     = bus.DATA_MEM_WRITE[2] ? 4'b0000 : bus.DATA_MEM_READ;
                m_addr   = bus.DATA_MEM_ADDR;
                m_wdata  = bus.DATA_MEM_WRITE_DATA;
                m_starve = i_r ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                grant_log.push_back(2);
            end else if (i_r) begin
                m_owner  = 1;
                m_rd     = 4'b1010;
                m_wr     = 3'b000;
                m_addr   = bus.INSTR_MEM_ADDR;
                m_starve = 0;
                grant_log.push_back(1);
            end
        end
    end

    int dut_seq[$];

    initial begin
        bus.INSTR_MEM_READ      = 1'b0;
        bus.INSTR_MEM_ADDR      = '0;
        bus.DATA_MEM_READ       = '0;
        bus.DATA_MEM_WRITE      = '0;
        bus.DATA_MEM_ADDR       = '0;
        bus.DATA_MEM_WRITE_DATA = '0;
        #1 RESET = 1'b0;
        #2;
        chk("rst_mem_read", bus.MEM_READ, 4'b0000);
        chk("rst_instr", bus.INSTRUCTION, 32'h0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;
        wait_n    = 0;
        fix_rdata = 32'h0000_10B7;

        // fetch only, zero-wait
        cyc();
        bus.INSTR_MEM_READ = 1'b1;
        bus.INSTR_MEM_ADDR = 32'h40;
        at_neg();
        chk("t1_c0_ibw", bus.INSTR_MEM_BUSYWAIT, 1'b1);
        chk("t1_c0_mrd", bus.MEM_READ, 4'b0000);
        cyc();
        at_neg();
        chk("t1_c1_mrd", bus.MEM_READ, 4'b1010);
        chk("t1_c1_addr", bus.MEM_ADDR, 32'h40);
        chk("t1_c1_ibw", bus.INSTR_MEM_BUSYWAIT, 1'b0);
        chk("t1_c1_instr", bus.INSTRUCTION, 32'h0000_10B7);
        cyc();
        bus.INSTR_MEM_READ = 1'b0;
        at_neg();
        chk("t1_c2_mrd", bus.MEM_READ, 4'b0000);
        chk("t1_c2_instr", bus.INSTRUCTION, 32'h0000_10B7);
        wait_n    = 3;
        fix_rdata = 32'h0000_0013;

        // simultaneous fetch and store, 3 wait cycles
        cyc();
        bus.INSTR_MEM_READ      = 1'b1;
        bus.INSTR_MEM_ADDR      = 32'h0;
        bus.DATA_MEM_WRITE      = 3'b110;
        bus.DATA_MEM_ADDR       = 32'h100;
        bus.DATA_MEM_WRITE_DATA = 32'hDEAD_BEEF;
        at_neg();
        chk("t2_c0_ibw", bus.INSTR_MEM_BUSYWAIT, 1'b1);
        chk("t2_c0_dbw", bus.DATA_MEM_BUSYWAIT, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            at_neg();
            chk("t2_mwr", bus.MEM_WRITE, 3'b110);
            chk("t2_mwdata", bus.MEM_WRITE_DATA, 32'hDEAD_BEEF);
            chk("t2_maddr", bus.MEM_ADDR, 32'h100);
            chk("t2_ibw", bus.INSTR_MEM_BUSYWAIT, 1'b1);
            chk("t2_dbw", bus.DATA_MEM_BUSYWAIT, (k == 4) ? 1'b0 : 1'b1);
        end
        cyc();
        bus.DATA_MEM_WRITE = 3'b000;
        at_neg();
        chk("t2_c5_mwr", bus.MEM_WRITE, 3'b000);
        chk("t2_c5_ibw", bus.INSTR_MEM_BUSYWAIT, 1'b1);
        for (int k = 6; k <= 9; k++) begin
            cyc();
            at_neg();
            chk("t2_fetch_mrd", bus.MEM_READ, 4'b1010);
            chk("t2_fetch_ibw", bus.INSTR_MEM_BUSYWAIT, (k == 9) ? 1'b0 : 1'b1);
            if (k == 9) chk("t2_fetch_instr", bus.INSTRUCTION, 32'h0000_0013);
        end
        cyc();
        bus.INSTR_MEM_READ = 1'b0;
        at_neg();
        wait_n = 0;

        // starvation guard: data held continuously, fetch pending
        cyc();
        grant_log.delete();
        bus.INSTR_MEM_READ = 1'b1;
        bus.INSTR_MEM_ADDR = 32'h80;
        bus.DATA_MEM_READ  = 4'b1010;
        bus.DATA_MEM_ADDR  = 32'h200;
        for (int c = 0; c < 20; c++) begin
            at_neg();
            if (bus.MEM_READ != 4'b0000) dut_seq.push_back((bus.MEM_ADDR == 32'h80) ? 1 : 2);
            cyc();
        end
        bus.INSTR_MEM_READ = 1'b0;
        bus.DATA_MEM_READ  = 4'b0000;
        chk("t3_dut_grants", dut_seq.size(), 10);
        chk("t3_model_grants", grant_log.size(), 10);
        if (dut_seq.size() >= 10 && grant_log.size() >= 10) begin
            for (int k = 0; k < 10; k++) begin
                chk("t3_dut_order", dut_seq[k], (k % 5 == 4) ? 1 : 2);
                chk("t3_model_order", grant_log[k], (k % 5 == 4) ? 1 : 2);
            end
        end
        at_neg();
        wait_n    = 3;
        fix_rdata = 32'h0000_CAFE;

        // data requester drops a load mid-grant
        cyc();
        bus.DATA_MEM_READ = 4'b1010;
        bus.DATA_MEM_ADDR = 32'h200;
        cyc();
        bus.DATA_MEM_READ = 4'b0000;
        bus.DATA_MEM_ADDR = 32'h999;
        for (int k = 1; k <= 4; k++) begin
            at_neg();
            chk("t4_mrd", bus.MEM_READ, 4'b1010);
            chk("t4_maddr", bus.MEM_ADDR, 32'h200);
            chk("t4_dbw", bus.DATA_MEM_BUSYWAIT, 1'b0);
            if (k == 4) chk("t4_rdata_pass", bus.DATA_MEM_READ_DATA, 32'h0000_CAFE);
            cyc();
        end
        at_neg();
        chk("t4_c5_mrd", bus.MEM_READ, 4'b0000);
        chk("t4_c5_rdata_held", bus.DATA_MEM_READ_DATA, 32'h0000_CAFE);

        // async reset in the middle of a store grant
        cyc();
        bus.DATA_MEM_WRITE      = 3'b110;
        bus.DATA_MEM_ADDR       = 32'h300;
        bus.DATA_MEM_WRITE_DATA = 32'h1234_5678;
        cyc();
        cyc();
        #1 RESET = 1'b0;
        #1;
        chk("t5_rst_mwr", bus.MEM_WRITE, 3'b000);
        chk("t5_rst_maddr", bus.MEM_ADDR, 32'h0);
        chk("t5_rst_mwdata", bus.MEM_WRITE_DATA, 32'h0);
        chk("t5_rst_dbw", bus.DATA_MEM_BUSYWAIT, 1'b1);
        chk("t5_rst_rdata", bus.DATA_MEM_READ_DATA, 32'h0);
        @(posedge CLK);
        #2 RESET = 1'b1;
        at_neg();
        chk("t5_rel_mwr", bus.MEM_WRITE, 3'b000);
        cyc();
        bus.DATA_MEM_WRITE = 3'b000;
        at_neg();
        chk("t5_reissue_mwr", bus.MEM_WRITE, 3'b110);
        chk("t5_reissue_maddr", bus.MEM_ADDR, 32'h300);
        repeat (5) cyc();
        at_neg();
        wait_n = 0;

        // read and write both set: store wins
        cyc();
        bus.DATA_MEM_READ  = 4'b1010;
        bus.DATA_MEM_WRITE = 3'b110;
        bus.DATA_MEM_ADDR  = 32'h400;
        cyc();
        at_neg();
        chk("t6_mwr", bus.MEM_WRITE, 3'b110);
        chk("t6_mrd", bus.MEM_READ, 4'b0000);
        chk("t6_maddr", bus.MEM_ADDR, 32'h400);
        cyc();
        bus.DATA_MEM_READ  = 4'b0000;
        bus.DATA_MEM_WRITE = 3'b000;
        at_neg();
        rand_wait = 1'b1;
        rand_data = 1'b1;

        // randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            cyc();
            RESET                   = ($urandom_range(0, 299) != 0);
            bus.INSTR_MEM_READ      = ($urandom_range(0, 9) < 7);
            bus.INSTR_MEM_ADDR      = $urandom;
            bus.DATA_MEM_READ       = {($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7))};
            bus.DATA_MEM_WRITE      = {($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3))};
            bus.DATA_MEM_ADDR       = $urandom;
            bus.DATA_MEM_WRITE_DATA = $urandom;
        end
        cyc();
        RESET = 1'b1;
        at_neg();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
